// File: rtl/data_mem_arbiter_if.sv
// Request/response port between one requester and the data memory arbiter.
interface data_mem_arbiter_if #(
    parameter int unsigned W = 8,
    parameter int unsigned A = 8
);
    logic         valid;
    logic         write;
    logic [A-1:0] addr;
    logic [W-1:0] wdata;
    logic         ready;
    logic         rvalid;
    logic [W-1:0] rdata;

    modport master (
        output valid, write, addr, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, write, addr, wdata,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter for the single-port data memory, with a zero-fill clear engine
// that takes the memory over for 2**A cycles.
module data_mem_arbiter #(
    parameter int unsigned W = 8,
    parameter int unsigned A = 8
) (
    input  logic                clk,
    input  logic                reset,
    data_mem_arbiter_if.slave   p0,
    data_mem_arbiter_if.slave   p1,
    input  logic                clear_start,
    output logic                clear_busy,
    output logic                clear_done,
    output logic [A-1:0]        mem_addr,
    output logic [W-1:0]        mem_data_to_write,
    output logic                mem_read_enabled,
    output logic                mem_write_enabled,
    input  logic [W-1:0]        mem_data_out
);
    typedef enum logic {StIdle, StClear} state_e;

    state_e       state_q;
    logic [A-1:0] cnt_q;
    logic         last_q;
    logic         rvalid0_q, rvalid1_q;
    logic [W-1:0] rdata0_q, rdata1_q;
    logic         done_q;
    logic         idle_free, grant0, grant1;

    // clear_start wins over both ports in the cycle it arrives
    assign idle_free  = (state_q == StIdle) && !clear_start;
    assign grant0     = idle_free && p0.valid && (!p1.valid || last_q);
    assign grant1     = idle_free && p1.valid && (!p0.valid || !last_q);
    assign clear_busy = (state_q == StClear) || ((state_q == StIdle) && clear_start);
    assign clear_done = done_q;

    assign p0.ready  = grant0;
    assign p1.ready  = grant1;
    assign p0.rvalid = rvalid0_q;
    assign p1.rvalid = rvalid1_q;
    assign p0.rdata  = rdata0_q;
    assign p1.rdata  = rdata1_q;

    always_comb begin
        mem_addr          = '0;
        mem_data_to_write = '0;
        mem_read_enabled  = 1'b0;
        mem_write_enabled = 1'b0;
        if (clear_busy) begin
            // counter sits at 0 in idle, so the start cycle writes address 0
            mem_addr          = cnt_q;
            mem_write_enabled = 1'b1;
        end else if (grant0) begin
            mem_addr          = p0.addr;
            mem_write_enabled = p0.write;
            mem_read_enabled  = !p0.write;
            mem_data_to_write = p0.write ? p0.wdata : '0;
        end else if (grant1) begin
            mem_addr          = p1.addr;
            mem_write_enabled = p1.write;
            mem_read_enabled  = !p1.write;
            mem_data_to_write = p1.write ? p1.wdata : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            rvalid0_q <= grant0 && !p0.write;
            rvalid1_q <= grant1 && !p1.write;
            if (grant0 && !p0.write) rdata0_q <= mem_data_out;
            if (grant1 && !p1.write) rdata1_q <= mem_data_out;
            if (grant0) begin
                last_q <= 1'b0;
            end else if (grant1) begin
                last_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (clear_start) begin
                        state_q <= StClear;
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                StClear: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == {A{1'b1}}) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomised scoreboard bench for data_mem_arbiter with a behavioural memory and reference model.
module tb_data_mem_arbiter;
    localparam int unsigned W = 8;
    localparam int unsigned A = 8;
    localparam int Depth = 256;

    typedef struct {
        int unsigned due;
        logic [7:0]  data;
    } exp_t;

    typedef struct {
        bit         write;
        logic [7:0] addr;
        logic [7:0] wdata;
    } req_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic clear_start, clear_busy, clear_done;
    logic [7:0] mem_addr, mem_wd, mem_dout;
    logic mem_re, mem_we;

    data_mem_arbiter_if #(.W(W), .A(A)) p0 ();
    data_mem_arbiter_if #(.W(W), .A(A)) p1 ();

    data_mem_arbiter #(.W(W), .A(A)) dut (
        .clk               (clk),
        .reset             (reset),
        .p0                (p0),
        .p1                (p1),
        .clear_start       (clear_start),
        .clear_busy        (clear_busy),
        .clear_done        (clear_done),
        .mem_addr          (mem_addr),
        .mem_data_to_write (mem_wd),
        .mem_read_enabled  (mem_re),
        .mem_write_enabled (mem_we),
        .mem_data_out      (mem_dout)
    );

    always #5 clk = ~clk;

    // Behavioural 256x8 memory: combinational read, write on posedge, no reset.
    logic [7:0] mem [Depth];
    logic [7:0] pre [Depth];
    logic       preload = 1'b0;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < Depth; i++) mem[i] <= pre[i];
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wd;
        end
    end
    assign mem_dout = mem[mem_addr];

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state, evaluated once per cycle from the spec's rules.
    logic [7:0] ref_mem [Depth];
    exp_t sb0[$];
    exp_t sb1[$];
    bit m_busy = 0, m_done = 0, m_last = 1;
    int m_cnt = 0;

    always @(negedge clk) begin
        bit st, g0, g1, w;
        logic [7:0] a, d;
        exp_t e;
        if (!reset) begin
            m_busy = 0; m_done = 0; m_last = 1; m_cnt = 0;
        end else begin
            st = !m_busy && clear_start;
            g0 = 0; g1 = 0;
            if (!m_busy && !st) begin
                if (p0.valid && p1.valid) begin
                    g0 = m_last; g1 = !m_last;
                end else begin
                    g0 = p0.valid; g1 = p1.valid;
                end
            end
            chk("p0_ready", 32'(p0.ready), 32'(g0));
            chk("p1_ready", 32'(p1.ready), 32'(g1));
            chk("clear_busy", 32'(clear_busy), 32'(m_busy || st));
            chk("clear_done", 32'(clear_done), 32'(m_done));
            if (clear_done) done_cnt++;
            if (m_busy || st) begin
                chk("clr_we", 32'(mem_we), 32'd1);
                chk("clr_re", 32'(mem_re), 32'd0);
                chk("clr_addr", 32'(mem_addr), 32'(m_cnt));
                chk("clr_data", 32'(mem_wd), 32'd0);
                ref_mem[m_cnt] = 8'h00;
            end else if (g0 || g1) begin
                w = g0 ? p0.write : p1.write;
                a = g0 ? p0.addr : p1.addr;
                d = g0 ? p0.wdata : p1.wdata;
                chk("acc_we", 32'(mem_we), 32'(w));
                chk("acc_re", 32'(mem_re), 32'(!w));
                chk("acc_addr", 32'(mem_addr), 32'(a));
                if (w) begin
                    chk("acc_wdata", 32'(mem_wd), 32'(d));
                    ref_mem[a] = d;
                end else begin
                    e.due = cyc + 1;
                    e.data = ref_mem[a];
                    if (g0) sb0.push_back(e);
                    else sb1.push_back(e);
                end
                m_last = g1;
            end else begin
                chk("idle_we", 32'(mem_we), 32'd0);
                chk("idle_re", 32'(mem_re), 32'd0);
                chk("idle_addr", 32'(mem_addr), 32'd0);
                chk("idle_data", 32'(mem_wd), 32'd0);
            end
            m_done = 0;
            if (st) begin
                m_busy = 1; m_cnt = 1;
            end else if (m_busy) begin
                if (m_cnt == Depth - 1) begin
                    m_busy = 0; m_done = 1; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever a port presents load data.
    logic [7:0] hold0 = 8'h00, hold1 = 8'h00;
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            sb0.delete(); sb1.delete();
            hold0 = 8'h00; hold1 = 8'h00;
        end else begin
            if (p0.rvalid) begin
                if (sb0.size() == 0 || sb0[0].due != cyc) begin
                    chk("p0_rvalid_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb0.pop_front();
                    chk("p0_rdata", 32'(p0.rdata), 32'(e.data));
                    hold0 = e.data;
                end
            end else begin
                if (sb0.size() > 0 && sb0[0].due == cyc) begin
                    chk("p0_rvalid_missing", 32'd0, 32'd1);
                    void'(sb0.pop_front());
                end
                chk("p0_rdata_hold", 32'(p0.rdata), 32'(hold0));
            end
            if (p1.rvalid) begin
                if (sb1.size() == 0 || sb1[0].due != cyc) begin
                    chk("p1_rvalid_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb1.pop_front();
                    chk("p1_rdata", 32'(p1.rdata), 32'(e.data));
                    hold1 = e.data;
                end
            end else begin
                if (sb1.size() > 0 && sb1[0].due == cyc) begin
                    chk("p1_rvalid_missing", 32'd0, 32'd1);
                    void'(sb1.pop_front());
                end
                chk("p1_rdata_hold", 32'(p1.rdata), 32'(hold1));
            end
        end
    end

    // Driver
    req_t rq0[$];
    req_t rq1[$];
    bit rnd = 0;

    function automatic req_t mk(input bit w, input logic [7:0] a, input logic [7:0] d);
        req_t r;
        r.write = w; r.addr = a; r.wdata = d;
        return r;
    endfunction

    task automatic cycle();
        if (rq0.size() > 0 && (p0.valid || !rnd || $urandom_range(0, 3) != 0)) begin
            p0.valid = 1'b1; p0.write = rq0[0].write; p0.addr = rq0[0].addr; p0.wdata = rq0[0].wdata;
        end else begin
            p0.valid = 1'b0; p0.write = 1'b0; p0.addr = 8'h00; p0.wdata = 8'h00;
        end
        if (rq1.size() > 0 && (p1.valid || !rnd || $urandom_range(0, 3) != 0)) begin
            p1.valid = 1'b1; p1.write = rq1[0].write; p1.addr = rq1[0].addr; p1.wdata = rq1[0].wdata;
        end else begin
            p1.valid = 1'b0; p1.write = 1'b0; p1.addr = 8'h00; p1.wdata = 8'h00;
        end
        @(negedge clk);
        if (p0.valid && p0.ready) void'(rq0.pop_front());
        if (p1.valid && p1.ready) void'(rq1.pop_front());
        @(posedge clk);
        #1;
        clear_start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((rq0.size() > 0 || rq1.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        if (rq0.size() > 0 || rq1.size() > 0) chk("drain_timeout", 32'd1, 32'd0);
        rq0.delete(); rq1.delete();
        cycle();
        cycle();
    endtask

    task automatic idle_inputs();
        p0.valid = 1'b0; p0.write = 1'b0; p0.addr = 8'h00; p0.wdata = 8'h00;
        p1.valid = 1'b0; p1.write = 1'b0; p1.addr = 8'h00; p1.wdata = 8'h00;
        clear_start = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_busy"}, 32'(clear_busy), 32'd0);
        chk({tag, "_done"}, 32'(clear_done), 32'd0);
        chk({tag, "_p0_rvalid"}, 32'(p0.rvalid), 32'd0);
        chk({tag, "_p1_rvalid"}, 32'(p1.rvalid), 32'd0);
        chk({tag, "_p0_rdata"}, 32'(p0.rdata), 32'd0);
        chk({tag, "_p1_rdata"}, 32'(p1.rdata), 32'd0);
    endtask

    task automatic pulse_reset();
        #2;
        reset = 1'b0;
        rq0.delete(); rq1.delete();
        idle_inputs();
        #1;
        reset_checks("abort");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        idle_inputs();
        for (int i = 0; i < Depth; i++) begin
            pre[i] = 8'($urandom);
            ref_mem[i] = pre[i];
        end
        preload = 1'b1;
        @(posedge clk);
        #1;
        preload = 1'b0;
        @(posedge clk);
        #1;
        reset_checks("reset");
        reset = 1'b1;
        cycle();

        // Store then load on port 0.
        rq0.push_back(mk(1, 8'h10, 8'hA5));
        rq0.push_back(mk(0, 8'h10, 8'h00));
        drain(20);

        // Both ports contend with loads from a fresh reset: p0 wins first.
        pulse_reset();
        rq0.push_back(mk(0, 8'h01, 8'h00));
        rq0.push_back(mk(0, 8'h01, 8'h00));
        rq1.push_back(mk(0, 8'h02, 8'h00));
        rq1.push_back(mk(0, 8'h02, 8'h00));
        drain(20);

        // Port 1 back-to-back stores then readback.
        for (int i = 0; i < 3; i++) rq1.push_back(mk(1, 8'(8'h20 + i), 8'(8'h11 + i)));
        for (int i = 0; i < 3; i++) rq1.push_back(mk(0, 8'(8'h20 + i), 8'h00));
        drain(20);

        // Full clear with port 0 waiting on a load.
        rq0.push_back(mk(1, 8'h00, 8'h7E));
        rq0.push_back(mk(1, 8'hFF, 8'h7E));
        drain(20);
        d0 = done_cnt;
        rq0.push_back(mk(0, 8'h00, 8'h00));
        rq0.push_back(mk(0, 8'hFF, 8'h00));
        clear_start = 1'b1;
        drain(400);
        chk("clear_done_count_full", 32'(done_cnt - d0), 32'd1);

        // Second clear_start mid-clear is ignored.
        rq0.push_back(mk(1, 8'hFF, 8'h7E));
        drain(20);
        d0 = done_cnt;
        clear_start = 1'b1;
        cycle();
        for (int i = 0; i < 49; i++) cycle();
        clear_start = 1'b1;
        cycle();
        for (int i = 0; i < 210; i++) cycle();
        chk("clear_done_count_restart", 32'(done_cnt - d0), 32'd1);

        // Reset at clear cycle 100 leaves memory partially cleared.
        rq0.push_back(mk(1, 8'hFF, 8'h7E));
        drain(20);
        d0 = done_cnt;
        clear_start = 1'b1;
        cycle();
        for (int i = 0; i < 100; i++) cycle();
        pulse_reset();
        for (int i = 0; i < 5; i++) cycle();
        chk("clear_done_after_abort", 32'(done_cnt - d0), 32'd0);
        rq0.push_back(mk(0, 8'h63, 8'h00));
        rq0.push_back(mk(0, 8'hFF, 8'h00));
        drain(20);

        // Random traffic on both ports with occasional clears.
        rnd = 1;
        for (int i = 0; i < 600; i++) begin
            if (rq0.size() < 2) rq0.push_back(mk(1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom)));
            if (rq1.size() < 2) rq1.push_back(mk(1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom)));
            if ($urandom_range(0, 199) == 0) clear_start = 1'b1;
            cycle();
        end
        drain(600);

        chk("sb0_empty", 32'(sb0.size()), 32'd0);
        chk("sb1_empty", 32'(sb1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
